uart_tx_param: RTL

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-entry holding buffer in front of the shift register,
// so the next byte can be queued while a frame is still on the line.
module uart_tx_param #(
  parameter int BAUD_DIV   = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_send,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [2:0]           tx_state
);

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud_div
      $error("uart_tx_param: BAUD_DIV must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_bad_parity_en
      $error("uart_tx_param: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1..2");
    end
  endgenerate

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY_ODD != 0) ? ~(^d) : (^d);
  endfunction

  state_t               r_state;
  logic [CW-1:0]        r_baud_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_empty;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic w_accept;
  logic w_bit_end;
  logic w_last_stop;
  logic w_load;

  // Accept, bit-boundary and frame-load decisions for this cycle.
  always_comb begin
    w_accept    = tx_send && r_hold_empty;
    w_bit_end   = (r_baud_cnt == CNT_MAX);
    w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == LAST_STOP);
    w_load      = !r_hold_empty && ((r_state == S_IDLE) || w_last_stop);
  end

  // Frame sequencer, holding buffer and registered line outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_empty <= 1'b1;
      r_parity     <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_hold       <= tx_data;
        r_hold_empty <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        S_START: begin
          if (w_bit_end) begin
            r_state    <= S_DATA;
            r_tx       <= r_shift[0];
            r_shift    <= {1'b0, r_shift[DATA_BITS-1:1]};
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state    <= S_STOP;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == LAST_STOP) begin
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
              r_tx      <= 1'b1;
              r_busy    <= 1'b0;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
      // A full buffer starts the next frame straight from IDLE or from the final stop bit.
      if (w_load) begin
        r_shift      <= r_hold;
        r_parity     <= calc_parity(r_hold);
        r_hold_empty <= 1'b1;
        r_state      <= S_START;
        r_tx         <= 1'b0;
        r_busy       <= 1'b1;
        r_baud_cnt   <= '0;
        r_bit_cnt    <= '0;
      end
    end
  end

  assign tx_ready = r_hold_empty;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign tx_done  = r_done;
  assign tx_state = r_state;

endmodule
